// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game state machine, goal detection, scoring and winner.
// Movement enable and ball re-centre are registered decodes of the next state.
module pong_match_ctrl #(
  parameter int LEFT_GOAL_X  = 10,
  parameter int RIGHT_GOAL_X = 620,
  parameter int BALL_W       = 10,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_TICKS  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_tick,
  input  logic       start,
  input  logic       pause,
  input  logic [9:0] ball_x,
  output logic       play_en,
  output logic       ball_rst,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       point_p1,
  output logic       point_p2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam int               CNT_W      = $clog2(SERVE_TICKS + 1);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [10:0]      LGX        = 11'(LEFT_GOAL_X);
  localparam logic [10:0]      RGX        = 11'(RIGHT_GOAL_X);
  localparam logic [10:0]      BW         = 11'(BALL_W);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_scorer;   // 0 = P1 scored, 1 = P2 scored
  logic [3:0]       r_p1_score;
  logic [3:0]       r_p2_score;
  logic             r_point_p1;
  logic             r_point_p2;
  logic [1:0]       r_winner;
  logic             r_play_en;
  logic             r_ball_rst;
  logic             w_play_en;
  logic             w_ball_rst;
  logic             w_left_goal;
  logic             w_right_goal;
  logic [3:0]       w_scorer_score;

  // 11-bit right-edge sum so a ball near x=1023 cannot wrap past the goal line
  assign w_left_goal    = ({1'b0, ball_x} <= LGX);
  assign w_right_goal   = (({1'b0, ball_x} + BW) >= RGX);
  assign w_scorer_score = r_scorer ? r_p2_score : r_p1_score;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_scorer   <= 1'b0;
      r_p1_score <= 4'd0;
      r_p2_score <= 4'd0;
      r_point_p1 <= 1'b0;
      r_point_p2 <= 1'b0;
      r_winner   <= 2'b00;
      r_play_en  <= 1'b0;
      r_ball_rst <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_play_en  <= w_play_en;
      r_ball_rst <= w_ball_rst;
      r_point_p1 <= 1'b0;
      r_point_p2 <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_p1_score <= 4'd0;
            r_p2_score <= 4'd0;
            r_winner   <= 2'b00;
            r_cnt      <= '0;
          end
        end
        S_SERVE: begin
          if (game_tick) r_cnt <= (r_cnt == SERVE_LAST) ? '0 : r_cnt + 1'b1;
        end
        S_PLAY: begin
          // Increment lands with the POINT entry so the pulse and new score coincide
          if (game_tick && w_left_goal) begin
            r_scorer   <= 1'b1;
            r_point_p2 <= 1'b1;
            if (r_p2_score < WIN) r_p2_score <= r_p2_score + 4'd1;
          end else if (game_tick && w_right_goal) begin
            r_scorer   <= 1'b0;
            r_point_p1 <= 1'b1;
            if (r_p1_score < WIN) r_p1_score <= r_p1_score + 4'd1;
          end
        end
        S_POINT: begin
          r_cnt <= '0;
          if (w_next == S_OVER) r_winner <= r_scorer ? 2'b10 : 2'b01;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SERVE;
      S_SERVE: if (game_tick && (r_cnt == SERVE_LAST)) w_next = S_PLAY;
      S_PLAY: begin
        if (game_tick && (w_left_goal || w_right_goal)) w_next = S_POINT;
        else if (pause)                                 w_next = S_PAUSE;
      end
      S_PAUSE: if (pause) w_next = S_PLAY;
      S_POINT: w_next = (w_scorer_score == WIN) ? S_OVER : S_SERVE;
      S_OVER:  if (start) w_next = S_SERVE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_play_en  = (w_next == S_PLAY);
    w_ball_rst = !((w_next == S_PLAY) || (w_next == S_PAUSE));
  end

  assign state    = r_state;
  assign play_en  = r_play_en;
  assign ball_rst = r_ball_rst;
  assign p1_score = r_p1_score;
  assign p2_score = r_p2_score;
  assign point_p1 = r_point_p1;
  assign point_p2 = r_point_p2;
  assign winner   = r_winner;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with SERVE_TICKS=4 and WIN_SCORE=3.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       rst, game_tick, start, pause;
  logic [9:0] ball_x;
  logic       play_en, ball_rst, point_p1, point_p2;
  logic [3:0] p1_score, p2_score;
  logic [1:0] winner;
  logic [2:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  pong_match_ctrl #(
    .LEFT_GOAL_X(10), .RIGHT_GOAL_X(620), .BALL_W(10),
    .WIN_SCORE(3), .SERVE_TICKS(4)
  ) dut (
    .clk(clk), .rst(rst), .game_tick(game_tick), .start(start), .pause(pause),
    .ball_x(ball_x), .play_en(play_en), .ball_rst(ball_rst),
    .p1_score(p1_score), .p2_score(p2_score), .point_p1(point_p1),
    .point_p2(point_p2), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, start, pause, tick;
    logic [9:0] bx;
    logic [2:0] st;
    logic [3:0] p1, p2;
    logic       pt1, pt2;
    logic [1:0] w;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, s, pa, t, input logic [9:0] bx,
                     input logic [2:0] st, input logic [3:0] p1, p2,
                     input logic pt1, pt2, input logic [1:0] w);
    vec_t v;
    v.rst = r; v.start = s; v.pause = pa; v.tick = t; v.bx = bx;
    v.st = st; v.p1 = p1; v.p2 = p2; v.pt1 = pt1; v.pt2 = pt2; v.w = w;
    vq.push_back(v);
  endtask

  // Three serve ticks stay in SERVE, the fourth enters PLAY
  task automatic serve_play(input logic [3:0] p1, p2);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 300, 1, p1, p2, 0, 0, 0);
    add(0, 0, 0, 1, 300, 2, p1, p2, 0, 0, 0);
  endtask

  function automatic logic [16:0] exp_vec(input logic [2:0] st, input logic [3:0] p1, p2,
                                          input logic pt1, pt2, input logic [1:0] w);
    logic pe, br;
    pe = (st == 3'd2);
    br = (st == 3'd0) || (st == 3'd1) || (st == 3'd3) || (st == 3'd5);
    return {st, pe, br, p1, p2, pt1, pt2, w};
  endfunction

  function automatic logic [16:0] act_vec();
    return {state, play_en, ball_rst, p1_score, p2_score, point_p1, point_p2, winner};
  endfunction

  task automatic check(input string name, input logic [16:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%0d pe=%0b br=%0b p1=%0d p2=%0d pt=%0b%0b w=%0b, want st=%0d pe=%0b br=%0b p1=%0d p2=%0d pt=%0b%0b w=%0b",
               name, act[16:14], act[13], act[12], act[11:8], act[7:4], act[3], act[2], act[1:0],
               exp[16:14], exp[13], exp[12], exp[11:8], exp[7:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic step(input logic r, s, pa, t, input logic [9:0] bx);
    @(negedge clk);
    rst = r; start = s; pause = pa; game_tick = t; ball_x = bx;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; game_tick = 1'b0; ball_x = 10'd300;

    // Reset, then a long idle stretch without start
    step(1, 0, 0, 0, 300);
    step(1, 0, 0, 0, 300);
    check("reset", act_vec(), exp_vec(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 1, 300);
      check($sformatf("idle_tick%0d", i), act_vec(), exp_vec(0, 0, 0, 0, 0, 0));
    end

    // Main scenario table
    add(1, 0, 0, 0, 300, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 300, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 300, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 300, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 300, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 300, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 300, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 300, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 300, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 300, 2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 5,   2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 5,   3, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 300, 1, 0, 1, 0, 0, 0);
    serve_play(0, 1);
    add(0, 0, 0, 1, 612, 3, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 300, 1, 1, 1, 0, 0, 0);
    serve_play(1, 1);
    add(0, 0, 0, 1, 300, 2, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 300, 4, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 5,   4, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 5,   4, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 5,   2, 1, 1, 0, 0, 0);
    add(0, 0, 1, 1, 5,   3, 1, 2, 0, 1, 0);
    add(0, 0, 1, 0, 300, 1, 1, 2, 0, 0, 0);
    serve_play(1, 2);
    add(0, 0, 0, 1, 611, 3, 2, 2, 1, 0, 0);
    add(0, 0, 0, 0, 300, 1, 2, 2, 0, 0, 0);
    serve_play(2, 2);
    add(0, 0, 0, 1, 609, 2, 2, 2, 0, 0, 0);
    add(0, 0, 0, 1, 610, 3, 3, 2, 1, 0, 0);
    add(0, 0, 0, 0, 300, 5, 3, 2, 0, 0, 1);
    add(0, 0, 0, 1, 5,   5, 3, 2, 0, 0, 1);
    add(0, 0, 1, 0, 5,   5, 3, 2, 0, 0, 1);
    add(0, 1, 0, 0, 300, 1, 0, 0, 0, 0, 0);
    serve_play(0, 0);
    add(0, 0, 0, 1, 10,  3, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 300, 1, 0, 1, 0, 0, 0);
    serve_play(0, 1);
    add(0, 0, 0, 1, 11,   2, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 1023, 3, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 300,  1, 1, 1, 0, 0, 0);
    serve_play(1, 1);
    add(0, 0, 0, 1, 612, 3, 2, 1, 1, 0, 0);
    add(0, 0, 0, 0, 300, 1, 2, 1, 0, 0, 0);
    serve_play(2, 1);
    add(0, 0, 1, 0, 300, 4, 2, 1, 0, 0, 0);
    add(1, 1, 0, 0, 300, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 300, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 300, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 300, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 300, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 300, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 300, 2, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 300, 2, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].start, vq[i].pause, vq[i].tick, vq[i].bx);
      check($sformatf("vec%0d", i), act_vec(),
            exp_vec(vq[i].st, vq[i].p1, vq[i].p2, vq[i].pt1, vq[i].pt2, vq[i].w));
    end

    // Long pause with the ball parked on the left goal line
    step(0, 0, 1, 0, 5);
    check("pause_enter", act_vec(), exp_vec(4, 0, 0, 0, 0, 0));
    for (int i = 0; i < 50; i++) begin
      step(0, 0, 0, 1, 5);
      check($sformatf("pause_tick%0d", i), act_vec(), exp_vec(4, 0, 0, 0, 0, 0));
    end
    step(0, 0, 1, 0, 5);
    check("pause_exit", act_vec(), exp_vec(2, 0, 0, 0, 0, 0));
    step(0, 0, 0, 1, 5);
    check("resume_goal", act_vec(), exp_vec(3, 0, 1, 0, 1, 0));
    step(0, 0, 0, 0, 300);
    check("resume_serve", act_vec(), exp_vec(1, 0, 1, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
